// File: rtl/jogador_pkg.sv
// Shared types and constants for the automatic player.
package jogador_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CAPTURA   = 3'd1,
    INTERVALO = 3'd2,
    PRESSIONA = 3'd3,
    FIM       = 3'd4
  } estado_t;

  localparam int DEPTH_PADRAO = 16;
  localparam int PRESS_PADRAO = 1000;
  localparam int GAP_PADRAO   = 1000;

  function automatic int clog2(input int valor);
    int r;
    r = 0;
    for (int v = valor - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/jogador_memoria.sv
// DEPTH x 4 register file holding the captured plays: synchronous write, asynchronous read.
module jogador_memoria
  import jogador_pkg::*;
#(
  parameter int DEPTH = DEPTH_PADRAO,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] addr_w,
  input  logic [3:0]    dado_w,
  input  logic [AW-1:0] addr_r,
  output logic [3:0]    dado_r
);

  logic [3:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem_q[addr_w] <= dado_w;
  end

  assign dado_r = mem_q[addr_r];

endmodule

// File: rtl/jogador_automatico.sv
// Automatic player: records the LED sequence of a round and replays it on the buttons.
// Optional macro JOGADOR_ERRO_INJETADO_EN adds forca_erro to corrupt the last replayed press.
module jogador_automatico
  import jogador_pkg::*;
#(
  parameter int DEPTH        = DEPTH_PADRAO,
  parameter int PRESS_CYCLES = PRESS_PADRAO,
  parameter int GAP_CYCLES   = GAP_PADRAO
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       habilita,
  input  logic [3:0] leds,
  input  logic       vez_jogador,
  input  logic       pronto,
`ifdef JOGADOR_ERRO_INJETADO_EN
  input  logic       forca_erro,
`endif
  output logic [3:0] botoes,
  output logic       ocupado,
  output logic       estouro,
  output logic [2:0] db_estado,
  output logic [3:0] db_ponteiro
);

  localparam int AW   = clog2(DEPTH);
  localparam int PW   = AW + 1;
  localparam int TMAX = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
  localparam int TW   = (clog2(TMAX) < 1) ? 1 : clog2(TMAX);

  estado_t         estado_q, estado_d;
  logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [3:0]      botoes_q, botoes_d;
  logic            estouro_q, estouro_d;
  logic [3:0]      leds_q, leds_ant_q;
  logic            vez_q, vez_ant_q;
  logic            mem_we;
  logic [3:0]      dado_r, valor_press;
  logic            flash, sobe, desce, ultimo;

  // Pins are registered before edge detection, so flash and turn edges line up.
  assign flash  = (leds_ant_q == 4'd0) && (leds_q != 4'd0);
  assign sobe   = vez_q && !vez_ant_q;
  assign desce  = !vez_q && vez_ant_q;
  assign ultimo = (rd_q == wr_q - PW'(1));

  jogador_memoria #(.DEPTH(DEPTH), .AW(AW)) u_memoria (
    .clock  (clock),
    .we     (mem_we),
    .addr_w (wr_q[AW-1:0]),
    .dado_w (leds_q),
    .addr_r (rd_q[AW-1:0]),
    .dado_r (dado_r)
  );

  always_comb begin
    valor_press = dado_r;
`ifdef JOGADOR_ERRO_INJETADO_EN
    if (forca_erro && ultimo) valor_press = {dado_r[2:0], dado_r[3]};
`endif
  end

  always_comb begin
    estado_d  = estado_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    timer_d   = timer_q;
    botoes_d  = 4'd0;
    estouro_d = estouro_q;
    mem_we    = 1'b0;

    case (estado_q)
      IDLE: begin
        wr_d    = '0;
        rd_d    = '0;
        timer_d = '0;
        if (habilita && !pronto) estado_d = CAPTURA;
      end
      CAPTURA: begin
        if (flash) begin
          if (wr_q == PW'(DEPTH)) begin
            estouro_d = 1'b1;
          end else begin
            mem_we = 1'b1;
            wr_d   = wr_q + PW'(1);
          end
        end
        // wr_d already counts a flash arriving in the same cycle as the turn edge.
        if (sobe) begin
          rd_d     = '0;
          timer_d  = '0;
          estado_d = (wr_d != '0) ? INTERVALO : FIM;
        end
      end
      INTERVALO: begin
        if (timer_q == TW'(GAP_CYCLES - 1)) begin
          timer_d  = '0;
          estado_d = PRESSIONA;
          botoes_d = valor_press;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      PRESSIONA: begin
        botoes_d = botoes_q;
        if (timer_q == TW'(PRESS_CYCLES - 1)) begin
          timer_d  = '0;
          rd_d     = rd_q + PW'(1);
          botoes_d = 4'd0;
          estado_d = ultimo ? FIM : INTERVALO;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      FIM: begin
        if (desce) begin
          wr_d     = '0;
          estado_d = CAPTURA;
        end
      end
      default: estado_d = IDLE;
    endcase

    // Game moved on to the next round mid-replay: abandon it and start capturing.
    if (((estado_q == INTERVALO) || (estado_q == PRESSIONA)) && desce) begin
      estado_d = CAPTURA;
      wr_d     = '0;
      timer_d  = '0;
      botoes_d = 4'd0;
    end
    if (!habilita || pronto) begin
      estado_d = IDLE;
      botoes_d = 4'd0;
      mem_we   = 1'b0;
    end
    if (estado_d == IDLE) estouro_d = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q   <= IDLE;
      wr_q       <= '0;
      rd_q       <= '0;
      timer_q    <= '0;
      botoes_q   <= 4'd0;
      estouro_q  <= 1'b0;
      leds_q     <= 4'd0;
      leds_ant_q <= 4'd0;
      vez_q      <= 1'b0;
      vez_ant_q  <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      timer_q    <= timer_d;
      botoes_q   <= botoes_d;
      estouro_q  <= estouro_d;
      leds_q     <= leds;
      leds_ant_q <= leds_q;
      vez_q      <= vez_jogador;
      vez_ant_q  <= vez_q;
    end
  end

  assign botoes      = botoes_q;
  assign estouro     = estouro_q;
  assign ocupado     = (estado_q == INTERVALO) || (estado_q == PRESSIONA);
  assign db_estado   = estado_q;
  assign db_ponteiro = 4'(ocupado ? rd_q : wr_q);

endmodule

// File: doc/jogador_automatico.md
Name: jogador_automatico

Overview:
- Automatic player that sits on the other end of the game's LED/button interface: it watches the `leds` sequence the game shows, records it, then replays it on `botoes` when the game signals `vez_jogador`.
- Used for demo mode on the FPGA and as a closed-loop stimulus generator for top-level benches.
- Drives the game's `botoes` input; reads the game's `leds`, `vez_jogador` and `pronto` outputs.

Parameters:
- DEPTH, 16, number of recordable plays per round (power of two).
- PRESS_CYCLES, 1000, clock cycles each replayed button stays pressed.
- GAP_CYCLES, 1000, idle clock cycles before each press (buttons released).

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- habilita  input  1  enables the player; low forces IDLE.
- leds  input  4  game LED outputs (one-hot while showing a play, 0 between plays).
- vez_jogador  input  1  game indicates the player's turn.
- pronto  input  1  game finished (won or lost).
- botoes  output  4  button drive to the game.
- ocupado  output  1  high while replaying.
- estouro  output  1  sticky: more than DEPTH LED flashes were seen in one round.
- db_estado  output  3  current state encoding.
- db_ponteiro  output  4  current write/read pointer (low 4 bits).

Behaviour:
- Interface and reset:
  - Single clock domain, clock `clock`. Reset `reset` is synchronous and active-high.
  - Reset values: botoes=0, ocupado=0, estouro=0, state=IDLE, wr_ptr=0, rd_ptr=0, timer=0. Memory contents are not reset.
- Registered inputs:
  - `leds` and `vez_jogador` are registered once (prev copies) for edge detection.
  - A flash is detected when leds_prev==0 and leds!=0.
- States:
  - IDLE: botoes=0. Go to CAPTURA when habilita=1 and pronto=0.
  - CAPTURA:
    - On each detected flash, store the leds value as-is at mem[wr_ptr], then wr_ptr++.
    - If wr_ptr==DEPTH, do not store; set estouro (cleared only by reset or IDLE entry).
    - On a vez_jogador rising edge: rd_ptr=0, timer=0, then go to INTERVALO if wr_ptr>0, else go to FIM.
  - INTERVALO: botoes=0, ocupado=1. Timer counts to GAP_CYCLES-1, then timer=0 and go to PRESSIONA.
  - PRESSIONA:
    - botoes=mem[rd_ptr], ocupado=1.
    - Timer counts to PRESS_CYCLES-1, then rd_ptr++ and timer=0.
    - If rd_ptr (before increment) == wr_ptr-1, go to FIM; else go to INTERVALO.
  - FIM: botoes=0, ocupado=0. On vez_jogador falling (game showing the next round): wr_ptr=0, go to CAPTURA.
- Global overrides, highest priority first:
  - reset.
  - habilita=0 → IDLE.
  - pronto=1 → IDLE (game over).
  - vez_jogador falling while in INTERVALO/PRESSIONA → abort replay: botoes=0, wr_ptr=0, go to CAPTURA in the next cycle.
- Boundary and timing rules:
  - A flash and a vez_jogador rising edge in the same cycle: store the flash first (the replay length includes it).
  - Latency: first press asserts GAP_CYCLES+2 cycles after the vez_jogador rising edge at the input pin.
  - botoes is registered; it is never nonzero outside PRESSIONA.
- Width rules:
  - Timer width is clog2(max(PRESS_CYCLES, GAP_CYCLES)).
  - Pointers are clog2(DEPTH)+1 bits, so DEPTH itself is representable.

Optional Feature:
- Macro JOGADOR_ERRO_INJETADO_EN.
- When defined:
  - Adds input `forca_erro` (1 bit).
  - If forca_erro=1 when the last play of a replay enters PRESSIONA, botoes drives mem[rd_ptr] rotated left by 1 (e.g. 0001→0010), deliberately losing the game to exercise the `perdeu` path.
- When undefined: no port; replay is always faithful.

Decomposition:
- Package jogador_pkg:
  - State enum (IDLE=0, CAPTURA=1, INTERVALO=2, PRESSIONA=3, FIM=4).
  - Default DEPTH/PRESS/GAP constants.
  - clog2 helper.
- Sub-module jogador_memoria: DEPTH×4 register file with synchronous write (we, addr_w, dado_w) and asynchronous read (addr_r).
- FSM, timer and pointers live in jogador_automatico.

Test Plan (PRESS_CYCLES=4, GAP_CYCLES=3):
1. Reset, habilita=1; flash leds 0001 then 0100 (3 cycles each, 2-cycle gaps); raise vez_jogador → botoes=0 for 3 cycles, 0001 for 4, 0 for 3, 0100 for 4, then 0; ocupado falls when entering FIM.
2. Round 2: vez_jogador falls; flash 0001, 0100, 1000; raise vez_jogador → replays exactly those 3 presses; db_ponteiro returns to 0 after vez_jogador fell.
3. Flash 17 times with DEPTH=16 → estouro=1; replay issues 16 presses; estouro stays high until habilita is toggled to 0.
4. Drop vez_jogador during the second PRESSIONA → botoes=0 the next cycle, state=CAPTURA, wr_ptr=0.
5. Assert pronto=1 mid-replay → next cycle botoes=0, state=IDLE; reset mid-CAPTURA → all outputs at reset values the next cycle.
6. With JOGADOR_ERRO_INJETADO_EN and forca_erro=1, sequence 0010,1000 → replay 0010 then 0001 (rotated); connected to the game top, perdeu asserts.
